// File: rtl/x_encoder_emulator.sv
// Quadrature A/B/Z transmitter: steps the encoder lines one count at a time toward a
// commanded signed position, at most one step every max(cfg_step_div_i,1) clocks.
module x_encoder_emulator #(
  parameter int POS_W = 32,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en_i,
  input  logic [DIV_W-1:0] cfg_step_div_i,
  input  logic [POS_W-1:0] cfg_index_period_i,
  input  logic             target_vld_i,
  input  logic [POS_W-1:0] target_pos_i,
  input  logic             load_vld_i,
  input  logic [POS_W-1:0] load_pos_i,
  output logic             x_encoder_a_out,
  output logic             x_encoder_b_out,
  output logic             x_encoder_z_out,
  output logic [POS_W-1:0] cur_pos_o,
  output logic             busy_o,
  output logic             at_target_o,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [POS_W-1:0] target;
  logic [POS_W-1:0] idx;
  logic [DIV_W-1:0] divider;

  logic [POS_W-1:0] diff;
  logic [POS_W-1:0] period_m1;
  logic [POS_W-1:0] idx_fwd;
  logic [POS_W-1:0] idx_rev;
  logic [POS_W-1:0] idx_next;
  logic [POS_W-1:0] pos_next;
  logic [DIV_W-1:0] div_reload;
  logic             moving;
  logic             fwd;
  logic             a_next;
  logic             b_next;
  logic             do_step;

  // Modular difference picks the shortest path; MSB set means the target is "behind".
  always_comb begin
    diff       = target - cur_pos_o;
    moving     = (diff != '0);
    fwd        = moving && !diff[POS_W-1];
    period_m1  = (cfg_index_period_i <= POS_W'(1)) ? '0 : cfg_index_period_i - POS_W'(1);
    idx_fwd    = (idx >= period_m1) ? '0 : idx + POS_W'(1);
    idx_rev    = ((idx == '0) || (idx > period_m1)) ? period_m1 : idx - POS_W'(1);
    idx_next   = fwd ? idx_fwd : idx_rev;
    pos_next   = fwd ? cur_pos_o + POS_W'(1) : cur_pos_o - POS_W'(1);
    // Forward walks 00->10->11->01; reverse is the inverse map.
    a_next     = fwd ? ~x_encoder_b_out : x_encoder_b_out;
    b_next     = fwd ? x_encoder_a_out  : ~x_encoder_a_out;
    div_reload = (cfg_step_div_i == '0) ? '0 : cfg_step_div_i - DIV_W'(1);
    do_step    = cfg_en_i && moving &&
                 ((state == STEP) || ((state == WAIT) && (divider == '0)));
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      target          <= '0;
      idx             <= '0;
      divider         <= '0;
      cur_pos_o       <= '0;
      x_encoder_a_out <= 1'b0;
      x_encoder_b_out <= 1'b0;
      x_encoder_z_out <= 1'b0;
      busy_o          <= 1'b0;
      at_target_o     <= 1'b1;
    end else begin
      busy_o      <= (cur_pos_o != target);
      at_target_o <= (cur_pos_o == target);
      if (load_vld_i) begin
        cur_pos_o       <= load_pos_i;
        target          <= load_pos_i;
        idx             <= '0;
        x_encoder_z_out <= 1'b0;
        divider         <= '0;
        state           <= IDLE;
      end else begin
        if (target_vld_i) begin
          target <= target_pos_i;
        end
        if (do_step) begin
          x_encoder_a_out <= a_next;
          x_encoder_b_out <= b_next;
          cur_pos_o       <= pos_next;
          idx             <= idx_next;
          x_encoder_z_out <= (idx_next == '0);
          divider         <= div_reload;
          state           <= WAIT;
        end else begin
          case (state)
            IDLE: begin
              if (cfg_en_i && moving) begin
                state <= STEP;
              end
            end
            STEP: begin
              // Target moved back onto the current position before the step fired.
              if (cfg_en_i && !moving) begin
                state <= IDLE;
              end
            end
            WAIT: begin
              if (cfg_en_i) begin
                if (divider == '0) begin
                  state <= IDLE;
                end else begin
                  divider <= divider - DIV_W'(1);
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
